// File: rtl/store_result_responder.sv
// Memory-side responder for the processor store bus: judges pass/fail/timeout
// from the store stream and keeps a first-word-fall-through log of accepted stores.
module store_result_responder #(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
  parameter int          LOG_DEPTH      = 8,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  input  logic        log_rd_en,
  output logic        log_empty,
  output logic        log_full,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow,
  output logic [15:0] store_count,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timed_out
);

  localparam int AW = $clog2(LOG_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  if (PASS_ADDR == SCRATCH_ADDR) begin : g_cfg_addr_err
    $error("store_result_responder: PASS_ADDR must differ from SCRATCH_ADDR");
  end
  if (LOG_DEPTH < 2 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_cfg_depth_err
    $error("store_result_responder: LOG_DEPTH must be a power of two, 2 or more");
  end

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cycle_cnt;
  logic            accept, pass_store, scratch_store;

  // Only a clean 1 counts as a strobe; X/Z on MemWrite is treated as idle.
  assign accept        = (MemWrite === 1'b1) && (state == ST_RUN);
  assign pass_store    = (DataAddr == PASS_ADDR) && (WriteData == PASS_DATA);
  assign scratch_store = (DataAddr == SCRATCH_ADDR);

  always_comb begin
    state_nxt = state;
    if (state == ST_RUN) begin
      if (accept && pass_store)                              state_nxt = ST_PASS;
      else if (accept && !scratch_store)                     state_nxt = ST_FAIL;
      else if (TIMEOUT_CYCLES != 0 && cycle_cnt == CNT_LAST) state_nxt = ST_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      cycle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RUN) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign done      = (state != ST_RUN);
  assign pass      = (state == ST_PASS);
  assign fail      = (state == ST_FAIL) || (state == ST_TIMEOUT);
  assign timed_out = (state == ST_TIMEOUT);

  logic [63:0]   mem [LOG_DEPTH];
  logic [63:0]   head, push_word;
  logic [PW-1:0] wptr, rptr, rptr_inc;
  logic [AW-1:0] widx, ridx, rnext_idx;
  logic          do_pop, do_push;

  assign widx      = wptr[AW-1:0];
  assign ridx      = rptr[AW-1:0];
  assign rptr_inc  = rptr + 1'b1;
  assign rnext_idx = rptr_inc[AW-1:0];
  assign push_word = {DataAddr, WriteData};

  assign log_empty = (wptr == rptr);
  assign log_full  = (wptr[PW-1] != rptr[PW-1]) && (widx == ridx);
  assign do_pop    = log_rd_en && !log_empty;
  assign do_push   = accept && (!log_full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[widx] <= push_word;
  end

  // Head register gives fall-through without a read path from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      head         <= '0;
      log_overflow <= 1'b0;
      store_count  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr_inc;
      if (do_pop)
        head <= (do_push && rnext_idx == widx) ? push_word : mem[rnext_idx];
      else if (do_push && log_empty)
        head <= push_word;
      if (accept && log_full && !do_pop) log_overflow <= 1'b1;
      if (accept && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
    end
  end

  assign log_addr = head[63:32];
  assign log_data = head[31:0];

endmodule

// File: tb/tb_store_result_responder.sv
// Randomized and directed bench for store_result_responder, checked against a
// queue-based reference model of the store/log rules.
module tb_store_result_responder;
  localparam int DEPTH = 4;
  localparam int TO    = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAddr = '0;
  logic [31:0] WriteData = '0;
  logic        log_rd_en = 1'b0;
  logic        log_empty, log_full, log_overflow;
  logic [31:0] log_addr, log_data;
  logic [15:0] store_count;
  logic        done, pass, fail, timed_out;

  always #5 clk = ~clk;

  store_result_responder #(
    .LOG_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .DataAddr(DataAddr), .WriteData(WriteData),
    .log_rd_en(log_rd_en), .log_empty(log_empty), .log_full(log_full), .log_addr(log_addr),
    .log_data(log_data), .log_overflow(log_overflow), .store_count(store_count),
    .done(done), .pass(pass), .fail(fail), .timed_out(timed_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0=run 1=pass 2=fail 3=timeout
  int          m_state, m_cyc, m_cnt;
  bit          m_ovf;
  logic [63:0] m_q[$];

  task automatic mdl_reset();
    m_state = 0; m_cyc = 0; m_cnt = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic mdl_edge(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rd);
    bit acc, pop;
    acc = (we === 1'b1) && (m_state == 0);
    pop = (rd === 1'b1) && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_q.size() < DEPTH) m_q.push_back({a, d});
      else m_ovf = 1;
    end
    if (m_state == 0) begin
      if (acc && a == 100 && d == 25) m_state = 1;
      else if (acc && a != 96)        m_state = 2;
      else if (m_cyc + 1 == TO)       m_state = 3;
      m_cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; MemWrite = 1'b0; log_rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_reset();
  endtask

  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rd);
    MemWrite = we; DataAddr = a; WriteData = d; log_rd_en = rd;
    @(posedge clk);
    mdl_edge(we, a, d, rd);
    #1;
    MemWrite = 1'b0; log_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({done, pass, fail, timed_out} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {done, pass, fail, timed_out});
    end
    n_checks++;
    if ({log_empty, log_full, log_overflow} !== 3'b100) begin
      n_fail++; $display("FAIL reset_log_flags: got %b want 100", {log_empty, log_full, log_overflow});
    end
    n_checks++;
    if ({log_addr, log_data, store_count} !== 80'd0) begin
      n_fail++; $display("FAIL reset_values: addr %0d data %0d count %0d want 0", log_addr, log_data, store_count);
    end
  endtask

  task automatic test_pass();
    logic [31:0] ea [3];
    logic [31:0] ed [3];
    ea = '{32'd96, 32'd96, 32'd100};
    ed = '{32'd10, 32'd7, 32'd25};
    do_reset();
    cycle(1'b1, 32'd96, 32'd10, 1'b0);
    cycle(1'b1, 32'd96, 32'd7, 1'b0);
    n_checks++;
    if ({done, pass} !== 2'b00) begin
      n_fail++; $display("FAIL pass_early: done/pass %b want 00", {done, pass});
    end
    cycle(1'b1, 32'd100, 32'd25, 1'b0);
    n_checks++;
    if ({done, pass, fail, timed_out} !== 4'b1100) begin
      n_fail++; $display("FAIL pass_flags: got %b want 1100", {done, pass, fail, timed_out});
    end
    n_checks++;
    if (store_count !== 16'd3) begin
      n_fail++; $display("FAIL pass_count: got %0d want 3", store_count);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({log_empty, log_addr, log_data} !== {1'b0, ea[i], ed[i]}) begin
        n_fail++; $display("FAIL pass_log[%0d]: empty %b (%0d,%0d) want (%0d,%0d)", i, log_empty, log_addr, log_data, ea[i], ed[i]);
      end
      cycle(1'b0, 32'd0, 32'd0, 1'b1);
    end
    n_checks++;
    if (log_empty !== 1'b1) begin
      n_fail++; $display("FAIL pass_log_drained: empty %b want 1", log_empty);
    end
  endtask

  task automatic test_fail();
    do_reset();
    cycle(1'b1, 32'd96, 32'd1, 1'b0);
    cycle(1'b1, 32'd104, 32'd5, 1'b0);
    n_checks++;
    if ({done, pass, fail, timed_out} !== 4'b1010) begin
      n_fail++; $display("FAIL fail_flags: got %b want 1010", {done, pass, fail, timed_out});
    end
    cycle(1'b1, 32'd100, 32'd25, 1'b0);
    n_checks++;
    if ({pass, fail, store_count} !== {2'b01, 16'd2}) begin
      n_fail++; $display("FAIL fail_ignore: pass %b fail %b count %0d want 0 1 2", pass, fail, store_count);
    end
    cycle(1'b0, 32'd0, 32'd0, 1'b1);
    n_checks++;
    if ({log_empty, log_addr, log_data} !== {1'b0, 32'd104, 32'd5}) begin
      n_fail++; $display("FAIL fail_log2: empty %b (%0d,%0d) want (104,5)", log_empty, log_addr, log_data);
    end
    cycle(1'b0, 32'd0, 32'd0, 1'b1);
    n_checks++;
    if (log_empty !== 1'b1) begin
      n_fail++; $display("FAIL fail_log_two_entries: empty %b want 1", log_empty);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (TO - 1) cycle(1'b0, 32'd0, 32'd0, 1'b0);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: done %b want 0 after %0d cycles", done, TO - 1);
    end
    cycle(1'b0, 32'd0, 32'd0, 1'b0);
    n_checks++;
    if ({done, pass, fail, timed_out} !== 4'b1011) begin
      n_fail++; $display("FAIL timeout_flags: got %b want 1011", {done, pass, fail, timed_out});
    end
    do_reset();
    repeat (TO - 1) cycle(1'b0, 32'd0, 32'd0, 1'b0);
    cycle(1'b1, 32'd100, 32'd25, 1'b0);
    n_checks++;
    if ({done, pass, fail, timed_out} !== 4'b1100) begin
      n_fail++; $display("FAIL timeout_pass_wins: got %b want 1100", {done, pass, fail, timed_out});
    end
    do_reset();
    repeat (TO - 1) cycle(1'b0, 32'd0, 32'd0, 1'b0);
    cycle(1'b1, 32'd96, 32'd9, 1'b0);
    n_checks++;
    if ({timed_out, store_count, log_empty, log_addr, log_data} !== {1'b1, 16'd1, 1'b0, 32'd96, 32'd9}) begin
      n_fail++; $display("FAIL timeout_scratch: to %b count %0d empty %b (%0d,%0d) want 1 1 0 (96,9)", timed_out, store_count, log_empty, log_addr, log_data);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] ed [4];
    ed = '{32'd2, 32'd3, 32'd4, 32'd6};
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(1'b1, 32'd96, 32'(i), 1'b0);
    n_checks++;
    if ({log_full, log_overflow, store_count} !== {2'b11, 16'd5}) begin
      n_fail++; $display("FAIL ovf_flags: full %b ovf %b count %0d want 1 1 5", log_full, log_overflow, store_count);
    end
    n_checks++;
    if (log_data !== 32'd1) begin
      n_fail++; $display("FAIL ovf_head: got %0d want 1", log_data);
    end
    cycle(1'b1, 32'd96, 32'd6, 1'b1);
    n_checks++;
    if ({log_full, log_overflow, store_count} !== {2'b11, 16'd6}) begin
      n_fail++; $display("FAIL ovf_push_pop: full %b ovf %b count %0d want 1 1 6", log_full, log_overflow, store_count);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({log_empty, log_data} !== {1'b0, ed[i]}) begin
        n_fail++; $display("FAIL ovf_log[%0d]: empty %b data %0d want %0d", i, log_empty, log_data, ed[i]);
      end
      cycle(1'b0, 32'd0, 32'd0, 1'b1);
    end
    n_checks++;
    if (log_empty !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drained: empty %b want 1", log_empty);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1'b1, 32'd100, 32'd24, 1'b0);
    n_checks++;
    if ({pass, fail} !== 2'b01) begin
      n_fail++; $display("FAIL wrong_data: pass/fail %b want 01", {pass, fail});
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({done, pass, fail, timed_out, log_empty, log_full, log_overflow, store_count, log_addr, log_data} !== {7'b0000100, 80'd0}) begin
      n_fail++; $display("FAIL async_reset: flags %b empty %b count %0d addr %0d data %0d want all reset", {done, pass, fail, timed_out}, log_empty, store_count, log_addr, log_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_reset();
    cycle(1'b1, 32'd100, 32'd25, 1'b0);
    n_checks++;
    if (pass !== 1'b1) begin
      n_fail++; $display("FAIL after_reset_pass: got %b want 1", pass);
    end
  endtask

  task automatic test_x_strobe();
    do_reset();
    cycle(1'bx, 32'd104, 32'd5, 1'b0);
    cycle(1'bz, 32'd104, 32'd5, 1'b0);
    n_checks++;
    if ({done, log_empty, store_count} !== {2'b01, 16'd0}) begin
      n_fail++; $display("FAIL x_strobe: done %b empty %b count %0d want 0 1 0", done, log_empty, store_count);
    end
    cycle(1'b1, 32'd96, 32'd3, 1'b0);
    n_checks++;
    if ({done, log_empty, store_count} !== {2'b00, 16'd1}) begin
      n_fail++; $display("FAIL x_then_store: done %b empty %b count %0d want 0 0 1", done, log_empty, store_count);
    end
  endtask

  task automatic test_random();
    logic        we, rd;
    logic [31:0] a, d;
    int          r;
    for (int round = 0; round < 6; round++) begin
      do_reset();
      for (int c = 0; c < TO + 4; c++) begin
        we = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 2) == 0);
        r  = $urandom_range(0, 19);
        d  = $urandom_range(0, 40);
        if (r == 0)      begin a = 32'd100; d = ($urandom_range(0, 1) == 0) ? 32'd25 : d; end
        else if (r == 1) a = 32'd104 + 32'($urandom_range(0, 8));
        else             a = 32'd96;
        cycle(we, a, d, rd);
        n_checks++;
        if ({done, pass, fail, timed_out} !== {m_state != 0, m_state == 1, m_state >= 2, m_state == 3}) begin
          n_fail++; $display("FAIL rnd_flags r%0d c%0d: got %b model state %0d", round, c, {done, pass, fail, timed_out}, m_state);
        end
        n_checks++;
        if ({store_count, log_empty, log_full, log_overflow} !== {16'(m_cnt), m_q.size() == 0, m_q.size() == DEPTH, m_ovf}) begin
          n_fail++; $display("FAIL rnd_log r%0d c%0d: count %0d e/f/o %b want %0d size %0d ovf %0d", round, c, store_count, {log_empty, log_full, log_overflow}, m_cnt, m_q.size(), m_ovf);
        end
        if (m_q.size() > 0) begin
          n_checks++;
          if ({log_addr, log_data} !== m_q[0]) begin
            n_fail++; $display("FAIL rnd_head r%0d c%0d: (%0d,%0d) want (%0d,%0d)", round, c, log_addr, log_data, m_q[0][63:32], m_q[0][31:0]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_overflow();
    test_async_reset();
    test_x_strobe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
